irs_block_free_manager: RTL and testbench
=========================================

Name: irs_block_free_manager

Overview:
- Responder for the readout processor's free-block handshake; owns the IRS block occupancy map.
- Sampling side marks blocks in use (alloc). Readout side returns them (free_req/free_ack).
- Tracks the used-block count, asserts a near-full flag back to the trigger/sampling logic, and latches sticky protocol errors for the status registers.

Parameters:
- NUM_BLOCKS, 512, number of IRS storage blocks tracked (one busy bit each).
- BLOCK_BITS, 9, width of a block address; clogb2(NUM_BLOCKS-1).
- FULL_THRESHOLD, 496, used_count at or above which blocks_full_o asserts.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- free_block_i  in  BLOCK_BITS  block address to free; valid with free_req_i
- free_req_i  in  1  one-cycle free request strobe
- free_ack_o  out  1  one-cycle pulse: free request retired
- alloc_block_i  in  BLOCK_BITS  block address being written by sampling logic
- alloc_i  in  1  one-cycle strobe: mark alloc_block_i busy
- query_block_i  in  BLOCK_BITS  block address for status query
- query_busy_o  out  1  busy bit of query_block_i, registered
- used_count_o  out  BLOCK_BITS+1  number of busy blocks
- blocks_full_o  out  1  used_count_o >= FULL_THRESHOLD
- err_clr_i  in  1  clears all sticky error bits
- err_o  out  3  sticky errors: [0] double free, [1] double alloc, [2] free overrun

Behaviour:
- Clocking and reset
  - Everything is on clk_i. rst_i is synchronous and active-high.
  - Reset values: busy map all 0, used_count_o=0, free_ack_o=0, query_busy_o=0, blocks_full_o=0, err_o=0, FSM=IDLE, pending request discarded.
  - Reset asserted mid-operation aborts any pending free. No ack is issued for it.
- Free FSM states: IDLE, CHECK, RETIRE.
  - IDLE: free_req_i=1 latches free_block_i into pend_addr, then goes to CHECK.
  - CHECK: reads busy[pend_addr] into pend_busy, then goes to RETIRE.
  - RETIRE: if pend_busy, clear busy[pend_addr] and decrement the count; else set err_o[0] and leave the map unchanged. free_ack_o=1 for exactly this cycle, then return to IDLE.
- Free latency: req in cycle N gives ack in cycle N+2. Ack is issued even on a double free, so the requester never hangs.
- free_req_i while FSM is not IDLE:
  - Request is dropped and err_o[2] is set.
  - The in-flight request completes normally.
  - Requester rule: at most one outstanding request; wait for free_ack_o.
- Alloc path (every cycle, independent of the FSM)
  - alloc_i with busy[alloc_block_i]=0: set the bit, increment the count.
  - alloc_i with the bit already 1: set err_o[1]. Map and count unchanged.
- Same-cycle interaction (RETIRE clearing block B while alloc_i sets block B)
  - The clear is applied first, then the set. Result: busy[B]=1, count unchanged, no error flagged.
  - CHECK sampling pend_addr in the same cycle as alloc_i to the same address samples the pre-alloc value.
- Count arithmetic
  - used_count_o is BLOCK_BITS+1 wide, so NUM_BLOCKS is representable.
  - Net update per cycle: +1 (alloc accepted), -1 (free retired), or 0 (both or neither).
  - The count never wraps: an alloc at count NUM_BLOCKS is impossible because every bit is already busy, so it flags err_o[1].
  - A decrement only occurs on a busy bit.
- blocks_full_o is registered, computed from the next-state count. It therefore updates in the same cycle as used_count_o.
- query_busy_o = busy[query_block_i] as of the previous clock edge's map state, one-cycle latency.
- Error bits
  - Set takes priority over err_clr_i in the same cycle.
  - Bits are only cleared by err_clr_i or rst_i.
- Addresses >= NUM_BLOCKS (only possible when NUM_BLOCKS is not a power of 2) are ignored for both alloc and free. A free to such an address still acks and sets err_o[0].

Test Plan:
- Reset, then alloc blocks 0x000, 0x1FF, 0x0A5 in consecutive cycles -> used_count_o=3; query 0x1FF gives query_busy_o=1 one cycle later; err_o=0.
- Free 0x0A5 (req cycle N) -> free_ack_o high only in N+2; used_count_o=2 at N+3; query 0x0A5 gives 0.
- Free 0x010 (never allocated) -> ack at N+2, used_count_o unchanged, err_o=3'b001; err_clr_i then gives err_o=0.
- Alloc 0x0A5 twice -> second alloc sets err_o[1], used_count_o rises by 1 only. Second free_req_i at N+1 -> err_o[2] set, only one ack.
- Alloc 496 distinct blocks -> blocks_full_o=1 in the same cycle used_count_o reaches 496. One free -> blocks_full_o=0.
- RETIRE of block 0x033 coincident with alloc_i of 0x033 -> busy[0x033]=1, count unchanged, no error. Assert rst_i during CHECK -> no ack, count=0, map clear.

Source files
------------

// File: rtl/irs_block_free_manager_if.sv
// rtl/irs_block_free_manager_if.sv - free/alloc/query/status bundle of the IRS block free manager
interface irs_block_free_manager_if #(
  parameter int BLOCK_BITS = 9
);
  logic [BLOCK_BITS-1:0] free_block;
  logic                  free_req;
  logic                  free_ack;
  logic [BLOCK_BITS-1:0] alloc_block;
  logic                  alloc;
  logic [BLOCK_BITS-1:0] query_block;
  logic                  query_busy;
  logic [BLOCK_BITS:0]   used_count;
  logic                  blocks_full;
  logic                  err_clr;
  logic [2:0]            err;

  modport master (
    output free_block, free_req, alloc_block, alloc, query_block, err_clr,
    input  free_ack, query_busy, used_count, blocks_full, err
  );

  modport slave (
    input  free_block, free_req, alloc_block, alloc, query_block, err_clr,
    output free_ack, query_busy, used_count, blocks_full, err
  );
endinterface

// File: rtl/irs_block_free_manager.sv
// rtl/irs_block_free_manager.sv - IRS block occupancy map with free handshake, used count and sticky errors
module irs_block_free_manager #(
  parameter int NUM_BLOCKS     = 512,
  parameter int BLOCK_BITS     = 9,
  parameter int FULL_THRESHOLD = 496
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  irs_block_free_manager_if.slave    bus
);
  localparam logic [BLOCK_BITS:0] FULL_W    = FULL_THRESHOLD[BLOCK_BITS:0];
  localparam logic [BLOCK_BITS:0] COUNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, CHECK, RETIRE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_BLOCKS-1:0]   busy_q, busy_d;
  logic [BLOCK_BITS:0]     count_q, count_d;
  logic [BLOCK_BITS-1:0]   pend_addr;
  logic                    pend_busy;
  logic                    full_q;
  logic                    qbusy_q;
  logic [2:0]              err_q;
  logic                    free_ack;
  logic                    retire_clr;
  logic                    double_free;
  logic                    dup_alloc;
  logic                    overrun;
  logic                    inc;
  logic                    dec;
  logic                    alloc_ok;
  logic                    free_ok;
  logic                    query_ok;

  // Out-of-range addresses only exist when the block count is not a power of two.
  if (NUM_BLOCKS == (1 << BLOCK_BITS)) begin : g_full_range
    assign alloc_ok = 1'b1;
    assign free_ok  = 1'b1;
    assign query_ok = 1'b1;
  end else begin : g_partial_range
    localparam logic [BLOCK_BITS:0] NB_W = NUM_BLOCKS[BLOCK_BITS:0];
    assign alloc_ok = ({1'b0, bus.alloc_block} < NB_W);
    assign free_ok  = ({1'b0, pend_addr} < NB_W);
    assign query_ok = ({1'b0, bus.query_block} < NB_W);
  end

  always_comb begin
    state_d     = state_q;
    free_ack    = 1'b0;
    retire_clr  = 1'b0;
    double_free = 1'b0;
    case (state_q)
      IDLE:    if (bus.free_req) state_d = CHECK;
      CHECK:   state_d = RETIRE;
      RETIRE: begin
        free_ack    = 1'b1;
        retire_clr  = pend_busy;
        double_free = ~pend_busy;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = bus.free_req && (state_q != IDLE);

  // Retire clear lands before the alloc set, so a same-block collision nets to busy with no error.
  always_comb begin
    busy_d    = busy_q;
    inc       = 1'b0;
    dec       = 1'b0;
    dup_alloc = 1'b0;
    if (retire_clr) begin
      busy_d[pend_addr] = 1'b0;
      dec               = 1'b1;
    end
    if (bus.alloc && alloc_ok) begin
      if (busy_d[bus.alloc_block]) begin
        dup_alloc = 1'b1;
      end else begin
        busy_d[bus.alloc_block] = 1'b1;
        inc                     = 1'b1;
      end
    end
    case ({inc, dec})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      count_q   <= '0;
      pend_addr <= '0;
      pend_busy <= 1'b0;
      full_q    <= 1'b0;
      qbusy_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.free_req) pend_addr <= bus.free_block;
      if (state_q == CHECK) pend_busy <= free_ok && busy_q[pend_addr];
      busy_q  <= busy_d;
      count_q <= count_d;
      full_q  <= (count_d >= FULL_W);
      qbusy_q <= query_ok && busy_q[bus.query_block];
      err_q   <= (err_q & ~{3{bus.err_clr}}) | {overrun, dup_alloc, double_free};
    end
  end

  assign bus.free_ack    = free_ack;
  assign bus.query_busy  = qbusy_q;
  assign bus.used_count  = count_q;
  assign bus.blocks_full = full_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_irs_block_free_manager.sv
// tb/tb_irs_block_free_manager.sv - directed self-checking bench for irs_block_free_manager
module tb_irs_block_free_manager;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  irs_block_free_manager_if #(.BLOCK_BITS(9)) bus ();

  irs_block_free_manager #(
    .NUM_BLOCKS(512), .BLOCK_BITS(9), .FULL_THRESHOLD(496)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    bus.free_block  = '0;
    bus.free_req    = 1'b0;
    bus.alloc_block = '0;
    bus.alloc       = 1'b0;
    bus.query_block = '0;
    bus.err_clr     = 1'b0;

    cyc(); cyc();
    rst_i = 1'b0;
    cyc();
    chk("rst_count", 32'(bus.used_count), 32'd0);
    chk("rst_ack", 32'(bus.free_ack), 32'd0);
    chk("rst_full", 32'(bus.blocks_full), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_qbusy", 32'(bus.query_busy), 32'd0);

    bus.alloc = 1'b1; bus.alloc_block = 9'h000; cyc();
    bus.alloc_block = 9'h1FF; cyc();
    bus.alloc_block = 9'h0A5; cyc();
    bus.alloc = 1'b0; bus.query_block = 9'h1FF;
    chk("alloc3_count", 32'(bus.used_count), 32'd3);
    cyc();
    chk("query_1ff", 32'(bus.query_busy), 32'd1);
    chk("alloc3_err", 32'(bus.err), 32'd0);

    bus.free_block = 9'h0A5; bus.free_req = 1'b1; cyc();
    bus.free_req = 1'b0;
    chk("free_a5_ack_n1", 32'(bus.free_ack), 32'd0);
    cyc();
    chk("free_a5_ack_n2", 32'(bus.free_ack), 32'd1);
    chk("free_a5_count_n2", 32'(bus.used_count), 32'd3);
    cyc();
    chk("free_a5_ack_n3", 32'(bus.free_ack), 32'd0);
    chk("free_a5_count_n3", 32'(bus.used_count), 32'd2);
    bus.query_block = 9'h0A5; cyc();
    chk("query_a5", 32'(bus.query_busy), 32'd0);

    bus.free_block = 9'h010; bus.free_req = 1'b1; cyc();
    bus.free_req = 1'b0; cyc();
    chk("dfree_ack_n2", 32'(bus.free_ack), 32'd1);
    cyc();
    chk("dfree_count", 32'(bus.used_count), 32'd2);
    chk("dfree_err", 32'(bus.err), 32'b001);
    bus.err_clr = 1'b1; cyc();
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.err), 32'd0);

    bus.alloc = 1'b1; bus.alloc_block = 9'h0A5; cyc();
    cyc();
    bus.alloc = 1'b0;
    chk("dalloc_count", 32'(bus.used_count), 32'd3);
    chk("dalloc_err", 32'(bus.err), 32'b010);

    bus.free_block = 9'h000; bus.free_req = 1'b1; cyc();
    bus.free_block = 9'h1FF;
    chk("ovr_ack_n1", 32'(bus.free_ack), 32'd0);
    cyc();
    bus.free_req = 1'b0;
    chk("ovr_ack_n2", 32'(bus.free_ack), 32'd1);
    chk("ovr_err", 32'(bus.err), 32'b110);
    cyc();
    chk("ovr_ack_n3", 32'(bus.free_ack), 32'd0);
    chk("ovr_count", 32'(bus.used_count), 32'd2);
    bus.query_block = 9'h1FF; cyc();
    chk("ovr_1ff_kept", 32'(bus.query_busy), 32'd1);
    chk("ovr_no_2nd_ack", 32'(bus.free_ack), 32'd0);

    rst_i = 1'b1; cyc();
    rst_i = 1'b0;
    bus.alloc = 1'b1;
    for (int i = 0; i < 495; i++) begin
      bus.alloc_block = 9'(i);
      cyc();
    end
    chk("fill495_count", 32'(bus.used_count), 32'd495);
    chk("fill495_full", 32'(bus.blocks_full), 32'd0);
    bus.alloc_block = 9'd495; cyc();
    bus.alloc = 1'b0;
    chk("fill496_count", 32'(bus.used_count), 32'd496);
    chk("fill496_full", 32'(bus.blocks_full), 32'd1);
    bus.free_block = 9'h000; bus.free_req = 1'b1; cyc();
    bus.free_req = 1'b0; cyc();
    chk("unfill_full_n2", 32'(bus.blocks_full), 32'd1);
    cyc();
    chk("unfill_count", 32'(bus.used_count), 32'd495);
    chk("unfill_full", 32'(bus.blocks_full), 32'd0);

    bus.free_block = 9'h033; bus.free_req = 1'b1; cyc();
    bus.free_req = 1'b0; cyc();
    chk("coll_ack", 32'(bus.free_ack), 32'd1);
    bus.alloc = 1'b1; bus.alloc_block = 9'h033; cyc();
    bus.alloc = 1'b0; bus.query_block = 9'h033;
    chk("coll_count", 32'(bus.used_count), 32'd495);
    chk("coll_err", 32'(bus.err), 32'd0);
    cyc();
    chk("coll_busy", 32'(bus.query_busy), 32'd1);

    bus.free_block = 9'h034; bus.free_req = 1'b1; cyc();
    bus.free_req = 1'b0;
    rst_i = 1'b1; cyc();
    rst_i = 1'b0;
    chk("rstchk_ack", 32'(bus.free_ack), 32'd0);
    chk("rstchk_count", 32'(bus.used_count), 32'd0);
    bus.query_block = 9'h034; cyc();
    chk("rstchk_ack2", 32'(bus.free_ack), 32'd0);
    chk("rstchk_map", 32'(bus.query_busy), 32'd0);
    chk("rstchk_full", 32'(bus.blocks_full), 32'd0);
    cyc();
    chk("rstchk_ack3", 32'(bus.free_ack), 32'd0);
    chk("rstchk_count2", 32'(bus.used_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
